harmonic_synth: RTL

//  Parametrised additive tone generator, N_HARM sine partials on one base frequency.

---
 rtl/harmonic_synth_pkg.sv | 30 +++
 rtl/sine_lut_rom.sv | 23 ++
 rtl/harmonic_synth.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/harmonic_synth_pkg.sv
// Shared types and constants for the additive tone generator: FSM states,
// sine table depth, output width helper and the sine table contents.
package harmonic_synth_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    localparam int LUT_ABITS_DEF = 9;
    localparam int LUT_DEPTH     = 1 << LUT_ABITS_DEF;

    function automatic int out_bits(int n_harm, int sig_bits, int a_bits);
        return sig_bits + a_bits + $clog2(n_harm);
    endfunction

    // Sine table entry: Bhaskara rational approximation over each half period,
    // scaled to the full positive range of a signed sbits-wide sample.
    function automatic longint sine_sample(int idx, int abits, int sbits);
        longint half;
        longint p;
        longint x;
        longint peak;
        longint v;
        half = longint'(1) << (abits - 1);
        p    = longint'(idx) % half;
        x    = p * (half - p);
        peak = (longint'(1) << (sbits - 1)) - 1;
        v    = (peak * 16 * x) / (5 * half * half - 4 * x);
        return (longint'(idx) >= half) ? -v : v;
    endfunction

endpackage

// File: rtl/sine_lut_rom.sv
// Synchronous single-port sine ROM, one full period, registered read (1-cycle latency).
module sine_lut_rom
    import harmonic_synth_pkg::*;
#(
    parameter int ABITS = LUT_ABITS_DEF,
    parameter int DBITS = 16
) (
    input  logic                    clk,
    input  logic [ABITS-1:0]        addr_i,
    output logic signed [DBITS-1:0] data_o
);

    logic signed [DBITS-1:0] rom [1 << ABITS];

    for (genvar gi = 0; gi < (1 << ABITS); gi++) begin : g_rom
        assign rom[gi] = DBITS'(sine_sample(gi, ABITS, DBITS));
    end

    always_ff @(posedge clk) begin
        data_o <= rom[addr_i];
    end

endmodule

// File: rtl/harmonic_synth.sv
// Additive tone generator: N_HARM sine partials share one time-multiplexed ROM,
// one partial per clock. Define TONE_GLIDE_EN for portamento on the base frequency.
module harmonic_synth
    import harmonic_synth_pkg::*;
#(
    parameter int N_HARM    = 8,
    parameter int F_BITS    = 12,
    parameter int M_BITS    = 4,
    parameter int A_BITS    = 3,
    parameter int SIG_BITS  = 16,
    parameter int ACC_BITS  = 32,
    parameter int LUT_ABITS = $clog2(LUT_DEPTH),
    parameter int PHASE_MSB = 22,
`ifdef TONE_GLIDE_EN
    parameter int GLIDE_STEP = 8,
`endif
    localparam int OUT_BITS = out_bits(N_HARM, SIG_BITS, A_BITS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [F_BITS-1:0]          freq,
    input  logic [N_HARM*M_BITS-1:0]   harm_mult,
    input  logic [N_HARM*A_BITS-1:0]   harm_amp,
    input  logic                       sample_tick,
    output logic signed [OUT_BITS-1:0] out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun
);

    localparam int KW = $clog2(N_HARM);

    state_t                       state_q;
    logic [KW-1:0]                k_q;
    logic                         drain_q;
    logic [F_BITS-1:0]            freq_eff_q;
    logic [F_BITS-1:0]            freq_eff_d;
    logic [ACC_BITS-1:0]          phase_q [N_HARM];
    logic signed [OUT_BITS-1:0]   sum_q;
    logic signed [OUT_BITS-1:0]   out_q;
    logic                         out_valid_q;
    logic                         overrun_q;
    logic                         mac_en_q;
    logic [A_BITS-1:0]            amp_s1_q;

    logic [M_BITS-1:0]            mult_k;
    logic [A_BITS-1:0]            amp_k;
    logic [F_BITS+M_BITS-1:0]     inc;
    logic [LUT_ABITS-1:0]         lut_addr;
    logic signed [SIG_BITS-1:0]   lut_data;
    logic signed [OUT_BITS-1:0]   term_d;

    assign mult_k   = harm_mult[int'(k_q)*M_BITS +: M_BITS];
    assign amp_k    = harm_amp[int'(k_q)*A_BITS +: A_BITS];
    assign inc      = {{M_BITS{1'b0}}, freq_eff_q} * {{F_BITS{1'b0}}, mult_k};
    assign lut_addr = phase_q[k_q][PHASE_MSB -: LUT_ABITS];

    sine_lut_rom #(
        .ABITS (LUT_ABITS),
        .DBITS (SIG_BITS)
    ) u_rom (
        .clk    (clk),
        .addr_i (lut_addr),
        .data_o (lut_data)
    );

    // Amplitude is treated as a non-negative signed gain so the product keeps the sine's sign.
    assign term_d = OUT_BITS'(lut_data) * OUT_BITS'($signed({1'b0, amp_s1_q}));

`ifdef TONE_GLIDE_EN
    localparam logic signed [F_BITS:0] STEP_S = (F_BITS+1)'(GLIDE_STEP);
    localparam logic [F_BITS-1:0]      STEP_U = F_BITS'(GLIDE_STEP);
    logic signed [F_BITS:0] freq_diff;

    assign freq_diff = $signed({1'b0, freq}) - $signed({1'b0, freq_eff_q});

    always_comb begin
        freq_eff_d = freq;
        if (freq_diff > STEP_S) begin
            freq_eff_d = freq_eff_q + STEP_U;
        end else if (freq_diff < -STEP_S) begin
            freq_eff_d = freq_eff_q - STEP_U;
        end
    end
`else
    assign freq_eff_d = freq;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            drain_q     <= 1'b0;
            freq_eff_q  <= '0;
            sum_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            amp_s1_q    <= '0;
            for (int i = 0; i < N_HARM; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            mac_en_q <= 1'b0;
            if (sample_tick && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            if (mac_en_q) begin
                sum_q <= sum_q + term_d;
            end
            case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        freq_eff_q <= freq_eff_d;
                        k_q        <= '0;
                        sum_q      <= '0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    // ROM is addressed with the old phase this cycle; write-back is the advanced one.
                    phase_q[k_q] <= phase_q[k_q] + ACC_BITS'(inc);
                    mac_en_q     <= 1'b1;
                    amp_s1_q     <= (mult_k == '0) ? '0 : amp_k;
                    if (k_q == KW'(N_HARM - 1)) begin
                        k_q     <= '0;
                        drain_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        out_q       <= sum_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule
